// File: rtl/cpu_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_sequencer_if
// Instruction-memory fetch handshake between the sequencer and the memory.
//
// Signals:
//   imem_req   sequencer -> memory  fetch request
//   imem_addr  sequencer -> memory  fetch address (the program counter)
//   imem_ack   memory -> sequencer  fetch acknowledge, data valid this cycle
//   imem_data  memory -> sequencer  instruction byte
//
// Modports:
//   master  the sequencer side
//   slave   the instruction-memory side
// ---------------------------------------------------------------------------
interface cpu_sequencer_if;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// lib_cpu
// Shared operation encoding between the external decoder and the sequencer.
// ---------------------------------------------------------------------------
package lib_cpu;
  typedef enum logic [3:0] {
    MOV_A_IMM = 4'd0,
    MOV_B_IMM = 4'd1,
    ADD_A_IMM = 4'd2,
    ADD_B_IMM = 4'd3,
    MOV_A_B   = 4'd4,
    MOV_B_A   = 4'd5,
    IN_A      = 4'd6,
    IN_B      = 4'd7,
    OUT_B     = 4'd8,
    OUT_IMM   = 4'd9,
    JMP_IMM   = 4'd10,
    JNC_IMM   = 4'd11,
    INVALID   = 4'd15
  } opecode_t;
endpackage

// ---------------------------------------------------------------------------
// cpu_sequencer
// Four-state (FETCH / DECODE / EXEC / HALT) sequencer for a tiny 4-bit CPU.
// It fetches one instruction byte per instruction over the imem handshake,
// holds it in ir for an external decoder, and commits the decoded operation
// (opecode/imm) to registers A/B, the carry flag, the output port and the pc.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   run        run enable; gates the start of a new fetch
//   imem       fetch handshake (cpu_sequencer_if.master)
//   ir         instruction register, feeds the external decoder
//   opecode    decoded operation for ir
//   imm        decoded 4-bit immediate for ir
//   in_port    external 4-bit input port
//   out_port   registered 4-bit output port
//   reg_a      general register A
//   reg_b      general register B
//   carry      carry flag
//   halted     high while the sequencer sits in HALT
//
// Parameter:
//   RESET_PC   program counter value loaded by reset
// ---------------------------------------------------------------------------
module cpu_sequencer #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  cpu_sequencer_if.master     imem,
  output logic [7:0]          ir,
  input  lib_cpu::opecode_t   opecode,
  input  logic [3:0]          imm,
  input  logic [3:0]          in_port,
  output logic [3:0]          out_port,
  output logic [3:0]          reg_a,
  output logic [3:0]          reg_b,
  output logic                carry,
  output logic                halted
);

  import lib_cpu::*;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  // 5-bit sum of a register and the immediate; bit 4 is the carry out.
  function automatic logic [4:0] add5(input logic [3:0] x, input logic [3:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Operations the sequencer knows how to commit; anything else halts.
  function automatic logic op_is_valid(input opecode_t op);
    logic valid;
    case (op)
      MOV_A_IMM, MOV_B_IMM, ADD_A_IMM, ADD_B_IMM,
      MOV_A_B,   MOV_B_A,   IN_A,      IN_B,
      OUT_B,     OUT_IMM,   JMP_IMM,   JNC_IMM: valid = 1'b1;
      default:                                 valid = 1'b0;
    endcase
    return valid;
  endfunction

  state_t     state_q, state_d;
  // Request register: lives only in FETCH, so imem_req is a pure function
  // of FSM state and is guaranteed low during and right after reset.
  logic       req_q, req_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] reg_a_q, reg_a_d;
  logic [3:0] reg_b_q, reg_b_d;
  logic [3:0] out_q, out_d;
  logic       carry_q, carry_d;
  logic       halted_q, halted_d;

  logic       fetch_done_s;
  logic       exec_valid_s;
  logic [3:0] pc_inc_s;
  logic [4:0] sum_a_s;
  logic [4:0] sum_b_s;

  assign fetch_done_s = (state_q == ST_FETCH) && req_q && imem.imem_ack;
  assign exec_valid_s = op_is_valid(opecode);

  // FSM state register together with the fetch-request flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // FSM next-state logic, including when a fetch request is raised or held.
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (req_q) begin
          // An outstanding request stays up until acked, whatever run does.
          if (imem.imem_ack) begin
            state_d = ST_DECODE;
            req_d   = 1'b0;
          end else begin
            state_d = ST_FETCH;
            req_d   = 1'b1;
          end
        end else begin
          // Idle in FETCH: an ack here is ignored, run starts a request.
          state_d = ST_FETCH;
          req_d   = run;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
        req_d   = 1'b0;
      end
      ST_EXEC: begin
        if (exec_valid_s) begin
          // Pre-arm the request so a zero-wait fetch keeps a 3-cycle period.
          state_d = ST_FETCH;
          req_d   = run;
        end else begin
          state_d = ST_HALT;
          req_d   = 1'b0;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
        req_d   = 1'b0;
      end
      default: begin
        state_d = ST_FETCH;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM outputs: the fetch handshake depends on state and pc only.
  always_comb begin
    if (state_q == ST_FETCH) begin
      imem.imem_req = req_q;
    end else begin
      imem.imem_req = 1'b0;
    end
    imem.imem_addr = pc_q;
  end

  // Datapath next-state: ir capture on fetch, architectural commit in EXEC.
  always_comb begin
    pc_inc_s = pc_q + 4'd1;
    sum_a_s  = add5(reg_a_q, imm);
    sum_b_s  = add5(reg_b_q, imm);
    pc_d     = pc_q;
    ir_d     = ir_q;
    reg_a_d  = reg_a_q;
    reg_b_d  = reg_b_q;
    out_d    = out_q;
    carry_d  = carry_q;
    halted_d = halted_q;

    if (fetch_done_s) begin
      ir_d = imem.imem_data;
    end else begin
      ir_d = ir_q;
    end

    if (state_q == ST_EXEC) begin
      case (opecode)
        ADD_A_IMM: begin
          reg_a_d = sum_a_s[3:0];
          carry_d = sum_a_s[4];
          pc_d    = pc_inc_s;
        end
        ADD_B_IMM: begin
          reg_b_d = sum_b_s[3:0];
          carry_d = sum_b_s[4];
          pc_d    = pc_inc_s;
        end
        MOV_A_IMM: begin
          reg_a_d = imm;
          carry_d = 1'b0;
          pc_d    = pc_inc_s;
        end
        MOV_B_IMM: begin
          reg_b_d = imm;
          carry_d = 1'b0;
          pc_d    = pc_inc_s;
        end
        MOV_A_B: begin
          reg_a_d = reg_b_q;
          carry_d = 1'b0;
          pc_d    = pc_inc_s;
        end
        MOV_B_A: begin
          reg_b_d = reg_a_q;
          carry_d = 1'b0;
          pc_d    = pc_inc_s;
        end
        IN_A: begin
          reg_a_d = in_port;
          carry_d = 1'b0;
          pc_d    = pc_inc_s;
        end
        IN_B: begin
          reg_b_d = in_port;
          carry_d = 1'b0;
          pc_d    = pc_inc_s;
        end
        OUT_B: begin
          out_d   = reg_b_q;
          carry_d = 1'b0;
          pc_d    = pc_inc_s;
        end
        OUT_IMM: begin
          out_d   = imm;
          carry_d = 1'b0;
          pc_d    = pc_inc_s;
        end
        JMP_IMM: begin
          carry_d = 1'b0;
          pc_d    = imm;
        end
        JNC_IMM: begin
          // The branch looks at the carry from before this instruction.
          if (carry_q) begin
            pc_d = pc_inc_s;
          end else begin
            pc_d = imm;
          end
          carry_d = 1'b0;
        end
        default: begin
          // INVALID (or any unknown code): freeze everything and halt.
          halted_d = 1'b1;
        end
      endcase
    end else begin
      halted_d = halted_q;
    end
  end

  // Datapath registers; reset aborts any in-flight fetch or commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      ir_q     <= 8'h00;
      reg_a_q  <= 4'h0;
      reg_b_q  <= 4'h0;
      out_q    <= 4'h0;
      carry_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      reg_a_q  <= reg_a_d;
      reg_b_q  <= reg_b_d;
      out_q    <= out_d;
      carry_q  <= carry_d;
      halted_q <= halted_d;
    end
  end

  assign ir       = ir_q;
  assign reg_a    = reg_a_q;
  assign reg_b    = reg_b_q;
  assign out_port = out_q;
  assign carry    = carry_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
// Self-checking bench for cpu_sequencer. The bench plays instruction memory
// and decoder, keeps its own architectural model, pushes the expected state
// after each instruction into a scoreboard queue when the instruction byte is
// acked, and pops/compares it once the EXEC commit is visible.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

  localparam logic [3:0] RESET_PC = 4'h0;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] out;
    logic [3:0] pc;
    logic       c;
    logic       h;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              run;
  logic [7:0]        ir;
  lib_cpu::opecode_t opecode;
  logic [3:0]        imm;
  logic [3:0]        in_port;
  logic [3:0]        out_port;
  logic [3:0]        reg_a;
  logic [3:0]        reg_b;
  logic              carry;
  logic              halted;

  cpu_sequencer_if imem_if ();

  cpu_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .imem     (imem_if),
    .ir       (ir),
    .opecode  (opecode),
    .imm      (imm),
    .in_port  (in_port),
    .out_port (out_port),
    .reg_a    (reg_a),
    .reg_b    (reg_b),
    .carry    (carry),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench decoder: high nibble selects the operation, low nibble is imm.
  always_comb begin
    imm = ir[3:0];
    case (ir[7:4])
      4'h0:    opecode = lib_cpu::MOV_A_IMM;
      4'h1:    opecode = lib_cpu::MOV_B_IMM;
      4'h2:    opecode = lib_cpu::ADD_A_IMM;
      4'h3:    opecode = lib_cpu::ADD_B_IMM;
      4'h4:    opecode = lib_cpu::MOV_A_B;
      4'h5:    opecode = lib_cpu::MOV_B_A;
      4'h6:    opecode = lib_cpu::IN_A;
      4'h7:    opecode = lib_cpu::IN_B;
      4'h9:    opecode = lib_cpu::OUT_B;
      4'hA:    opecode = lib_cpu::OUT_IMM;
      4'hB:    opecode = lib_cpu::JMP_IMM;
      4'hC:    opecode = lib_cpu::JNC_IMM;
      default: opecode = lib_cpu::INVALID;
    endcase
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  int   last_ack_cyc;

  logic [3:0] m_a, m_b, m_out, m_pc;
  logic       m_c, m_h;
  logic [7:0] m_ir;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a = 4'h0; m_b = 4'h0; m_out = 4'h0; m_pc = RESET_PC;
    m_c = 1'b0; m_h = 1'b0; m_ir = 8'h00;
    sb_q.delete();
  endtask

  // Reference behaviour of one instruction byte.
  task automatic model_step(input logic [7:0] d, input logic [3:0] inp);
    logic [3:0] k;
    logic [4:0] s;
    k = d[3:0];
    case (d[7:4])
      4'h0: begin m_a = k;       m_c = 1'b0; m_pc = m_pc + 4'd1; end
      4'h1: begin m_b = k;       m_c = 1'b0; m_pc = m_pc + 4'd1; end
      4'h2: begin s = {1'b0, m_a} + {1'b0, k}; m_a = s[3:0]; m_c = s[4]; m_pc = m_pc + 4'd1; end
      4'h3: begin s = {1'b0, m_b} + {1'b0, k}; m_b = s[3:0]; m_c = s[4]; m_pc = m_pc + 4'd1; end
      4'h4: begin m_a = m_b;     m_c = 1'b0; m_pc = m_pc + 4'd1; end
      4'h5: begin m_b = m_a;     m_c = 1'b0; m_pc = m_pc + 4'd1; end
      4'h6: begin m_a = inp;     m_c = 1'b0; m_pc = m_pc + 4'd1; end
      4'h7: begin m_b = inp;     m_c = 1'b0; m_pc = m_pc + 4'd1; end
      4'h9: begin m_out = m_b;   m_c = 1'b0; m_pc = m_pc + 4'd1; end
      4'hA: begin m_out = k;     m_c = 1'b0; m_pc = m_pc + 4'd1; end
      4'hB: begin m_pc = k;      m_c = 1'b0; end
      4'hC: begin
        if (m_c) m_pc = m_pc + 4'd1;
        else     m_pc = k;
        m_c = 1'b0;
      end
      default: m_h = 1'b1;
    endcase
  endtask

  // Wait for the request, optionally stall, ack the byte; ends after the ack edge.
  task automatic start_fetch(input logic [7:0] d, input int delay, input bit drop_run);
    int n;
    n = 0;
    while (imem_if.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("req_seen", {7'h0, imem_if.imem_req}, 8'h01);
    check_val("fetch_addr", {4'h0, imem_if.imem_addr}, {4'h0, m_pc});
    for (int i = 0; i < delay; i++) begin
      imem_if.imem_ack = 1'b0;
      if (drop_run && i == 1) run = 1'b0;
      @(negedge clk);
      check_val("req_hold", {7'h0, imem_if.imem_req}, 8'h01);
    end
    last_ack_cyc      = cyc;
    imem_if.imem_ack  = 1'b1;
    imem_if.imem_data = d;
    m_ir = d;
    model_step(d, in_port);
    sb_q.push_back('{a: m_a, b: m_b, out: m_out, pc: m_pc, c: m_c, h: m_h});
    @(negedge clk);
    imem_if.imem_ack  = 1'b0;
    imem_if.imem_data = 8'($urandom_range(0, 255));
    check_val("ir_load", ir, m_ir);
  endtask

  // DECODE then EXEC; compare the committed state against the scoreboard.
  task automatic finish_exec();
    exp_t e;
    @(negedge clk);
    check_val("decode_halted", {7'h0, halted}, 8'h00);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 8'h01, 8'h00);
    end else begin
      e = sb_q.pop_front();
      check_val("reg_a",    {4'h0, reg_a},           {4'h0, e.a});
      check_val("reg_b",    {4'h0, reg_b},           {4'h0, e.b});
      check_val("carry",    {7'h0, carry},           {7'h0, e.c});
      check_val("out_port", {4'h0, out_port},        {4'h0, e.out});
      check_val("pc",       {4'h0, imem_if.imem_addr}, {4'h0, e.pc});
      check_val("halted",   {7'h0, halted},          {7'h0, e.h});
    end
  endtask

  task automatic do_instr(input logic [7:0] d, input int delay, input bit drop_run);
    start_fetch(d, delay, drop_run);
    finish_exec();
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_ir"},     ir,                        8'h00);
    check_val({tag, "_a"},      {4'h0, reg_a},             8'h00);
    check_val({tag, "_b"},      {4'h0, reg_b},             8'h00);
    check_val({tag, "_out"},    {4'h0, out_port},          8'h00);
    check_val({tag, "_carry"},  {7'h0, carry},             8'h00);
    check_val({tag, "_halted"}, {7'h0, halted},            8'h00);
    check_val({tag, "_req"},    {7'h0, imem_if.imem_req},  8'h00);
    check_val({tag, "_addr"},   {4'h0, imem_if.imem_addr}, {4'h0, RESET_PC});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_first;
    rst_n = 1'b0;
    run = 1'b1;
    in_port = 4'h0;
    imem_if.imem_ack  = 1'b0;
    imem_if.imem_data = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;

    // Zero-wait program: MOV_A 3, ADD_A 14, JNC 0, OUT_IMM 5.
    do_instr(8'h03, 0, 1'b0);
    t_first = last_ack_cyc;
    do_instr(8'h2E, 0, 1'b0);
    check_val("prog_add_a", {4'h0, reg_a}, 8'h01);
    check_val("prog_add_c", {7'h0, carry}, 8'h01);
    do_instr(8'hC0, 0, 1'b0);
    check_val("prog_jnc_pc", {4'h0, imem_if.imem_addr}, 8'h03);
    do_instr(8'hA5, 0, 1'b0);
    check_val("prog_out", {4'h0, out_port}, 8'h05);
    check_val("prog_cycles", 8'(cyc - t_first), 8'd12);

    // JNC taken with carry clear, jump to 15, wrap past 15.
    do_instr(8'hC7, 0, 1'b0);
    check_val("jnc7_pc", {4'h0, imem_if.imem_addr}, 8'h07);
    check_val("jnc7_c", {7'h0, carry}, 8'h00);
    do_instr(8'hBF, 0, 1'b0);
    do_instr(8'h19, 0, 1'b0);
    check_val("wrap_b", {4'h0, reg_b}, 8'h09);
    check_val("wrap_pc", {4'h0, imem_if.imem_addr}, 8'h00);

    // Remaining operations.
    in_port = 4'h6;
    do_instr(8'h38, 0, 1'b0);
    do_instr(8'h40, 0, 1'b0);
    do_instr(8'h70, 0, 1'b0);
    do_instr(8'h50, 0, 1'b0);
    in_port = 4'hC;
    do_instr(8'h60, 1, 1'b0);
    do_instr(8'h90, 0, 1'b0);
    do_instr(8'h24, 0, 1'b0);
    do_instr(8'hC2, 2, 1'b0);

    // Delayed ack with run dropped while waiting.
    do_instr(8'h1D, 4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("idle_req", {7'h0, imem_if.imem_req}, 8'h00);
    end
    // Stray ack with no request must not load ir.
    imem_if.imem_ack  = 1'b1;
    imem_if.imem_data = 8'hFF;
    @(negedge clk);
    imem_if.imem_ack  = 1'b0;
    check_val("stray_ack_ir", ir, m_ir);
    check_val("stray_ack_req", {7'h0, imem_if.imem_req}, 8'h00);
    run = 1'b1;

    // Reset pulse during EXEC of ADD_B_IMM.
    do_instr(8'h2F, 0, 1'b0);
    start_fetch(8'h3F, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("exec_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_instr(8'h01, 0, 1'b0);
    do_instr(8'h1A, 0, 1'b0);

    // INVALID halts and freezes everything until reset.
    do_instr(8'h80, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("halt_req", {7'h0, imem_if.imem_req}, 8'h00);
      check_val("halt_flag", {7'h0, halted}, 8'h01);
    end
    check_val("halt_a", {4'h0, reg_a}, {4'h0, m_a});
    check_val("halt_b", {4'h0, reg_b}, {4'h0, m_b});
    rst_n = 1'b0;
    #1;
    check_reset_state("final_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_instr(8'h07, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter: RESET_PC, default 4'h0, program counter value loaded at reset.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  run enable; when low, no new fetch SHALL start.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  4  fetch address; equals pc.
REQ-007 imem_ack  input  1  fetch acknowledge; imem_data is valid in the same cycle.
REQ-008 imem_data  input  8  fetched instruction byte.
REQ-009 ir  output  8  instruction register; drives the decoder fetch input.
REQ-010 opecode  input  OPECODE (lib_cpu)  decoded operation for ir.
REQ-011 imm  input  4  decoded immediate for ir.
REQ-012 in_port  input  4  external input port.
REQ-013 out_port  output  4  registered output port.
REQ-014 reg_a, reg_b  output  4 each  general registers A and B.
REQ-015 carry  output  1  carry flag.
REQ-016 halted  output  1  high while in HALT.

Function
REQ-017 FSM states SHALL be FETCH, DECODE, EXEC and HALT.
REQ-018 FETCH behaviour:
  - imem_req SHALL be high when run=1 or a request is already outstanding.
  - Once raised, imem_req SHALL stay high until imem_ack, even if run drops.
  - On imem_req=1 and imem_ack=1, ir SHALL load imem_data and the FSM SHALL go to DECODE.
REQ-019 imem_ack while imem_req=0 SHALL be ignored.
REQ-020 DECODE SHALL last exactly one cycle, then go to EXEC; no architectural state changes in DECODE.
REQ-021 EXEC SHALL last one cycle and commit per opecode, with S = reg + imm 5-bit:
  - ADD_A_IMM: reg_a = S[3:0], carry = S[4].
  - ADD_B_IMM: reg_b = S[3:0], carry = S[4].
  - MOV_A_IMM / MOV_B_IMM: load imm into A / B.
  - MOV_A_B: A = B.  MOV_B_A: B = A.
  - IN_A / IN_B: load in_port into A / B.
  - OUT_B: out_port = B.  OUT_IMM: out_port = imm.
REQ-022 Every non-ADD instruction SHALL clear carry in EXEC; JNC SHALL test the carry value held before that EXEC.
REQ-023 PC update in EXEC:
  - JMP_IMM: pc = imm.
  - JNC_IMM: pc = imm if carry=0, else pc+1.
  - All others: pc+1, modulo 16 (15 wraps to 0).
REQ-024 EXEC with opecode INVALID SHALL go to HALT and change no register, pc, carry or out_port.
REQ-025 HALT SHALL be left only by reset; halted=1 and imem_req=0 while in HALT.
REQ-026 Minimum instruction period SHALL be 3 cycles (FETCH with immediate ack, DECODE, EXEC); each wait cycle without ack adds one cycle.
REQ-027 All outputs SHALL be registered except imem_req and imem_addr, which SHALL be driven from FSM state and pc only.

Reset
REQ-028 rst_n=0 SHALL immediately force:
  - state FETCH, pc = RESET_PC;
  - ir, reg_a, reg_b, out_port = 0;
  - carry = 0, halted = 0, imem_req = 0.
REQ-029 Reset asserted mid-fetch or mid-EXEC SHALL abort the operation with no partial commit; after deassertion the first request SHALL be to RESET_PC when run=1.

Verification
REQ-030 Zero-wait program MOV_A_IMM 3, ADD_A_IMM 14, JNC 0, OUT_IMM 5:
  - after the ADD: reg_a = 1, carry = 1;
  - JNC not taken, so pc goes to 3;
  - out_port = 5 at instruction 4, cycle 12.
REQ-031 ack delayed 4 cycles with run dropped during the wait:
  - imem_req holds high until ack;
  - ir loads the acked byte;
  - afterwards no new fetch starts while run = 0.
REQ-032 pc = 15 with MOV_B_IMM 9: reg_b = 9 and the next imem_addr = 0.
REQ-033 JNC 7 with carry = 0: the next imem_addr = 7 and carry stays 0.
REQ-034 imem_data 8'h80 (INVALID):
  - halted = 1 two cycles after the ack;
  - registers unchanged;
  - imem_req stays 0 until reset.
REQ-035 rst_n pulsed low during EXEC of ADD_B_IMM:
  - reg_b = 0, carry = 0, pc = RESET_PC;
  - the first request after reset is to RESET_PC.
